// File: rtl/plab1_imul_var_lat_ctrl_pkg.sv
// Shared encodings for the variable-latency iterative multiplier.
// State codes and datapath mux select values.
package plab1_imul_var_lat_ctrl_pkg;

    typedef enum logic [1:0] {
        STATE_IDLE = 2'd0,
        STATE_CALC = 2'd1,
        STATE_DONE = 2'd2
    } state_t;

    localparam logic A_MUX_SEL_LD        = 1'b0;
    localparam logic A_MUX_SEL_SHIFT     = 1'b1;
    localparam logic B_MUX_SEL_LD        = 1'b0;
    localparam logic B_MUX_SEL_SHIFT     = 1'b1;
    localparam logic RESULT_MUX_SEL_CLR  = 1'b0;
    localparam logic RESULT_MUX_SEL_ADD  = 1'b1;

endpackage

// File: rtl/plab1_imul_var_lat_ctrl_count_zeros.sv
// 8-bit trailing-zero counter; returns 8 when no bit is set.
module plab1_imul_CountZeros (
    input  logic [7:0] bits,
    output logic [3:0] count
);

    // Scan from the top so the lowest set bit wins.
    always_comb begin
        count = 4'd8;
        for (int i = 7; i >= 0; i--) begin
            if (bits[i]) count = 4'(i);
        end
    end

endmodule

// File: rtl/plab1_imul_var_lat_ctrl.sv
// Control unit for the variable-latency iterative multiplier:
// sequences load, add and zero-run skipping on the shift/add datapath.
module plab1_imul_var_lat_ctrl
    import plab1_imul_var_lat_ctrl_pkg::*;
#(
    parameter int p_nbits = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_val,
    output logic                          req_rdy,
    output logic                          resp_val,
    input  logic                          resp_rdy,
    input  logic [7:0]                    b_lsbs,
    input  logic                          b_zero,
    output logic                          a_mux_sel,
    output logic                          b_mux_sel,
    output logic                          result_mux_sel,
    output logic                          result_en,
    output logic                          add_en,
    output logic [3:0]                    shamt,
    output logic [$clog2(p_nbits)+1:0]    calc_count
);

    state_t     state;
    logic [3:0] cz;

    plab1_imul_CountZeros count_zeros (
        .bits  (b_lsbs),
        .count (cz)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= STATE_IDLE;
            calc_count <= '0;
        end else begin
            unique case (state)
                STATE_IDLE: begin
                    if (req_val) begin
                        state      <= STATE_CALC;
                        calc_count <= '0;
                    end
                end
                STATE_CALC: begin
                    if (calc_count != '1) calc_count <= calc_count + 1'b1;
                    if (b_zero) state <= STATE_DONE;
                end
                STATE_DONE: begin
                    if (resp_rdy) state <= STATE_IDLE;
                end
                default: state <= STATE_IDLE;
            endcase
        end
    end

    // Everything is forced low while reset is held.
    always_comb begin
        req_rdy        = 1'b0;
        resp_val       = 1'b0;
        a_mux_sel      = A_MUX_SEL_LD;
        b_mux_sel      = B_MUX_SEL_LD;
        result_mux_sel = RESULT_MUX_SEL_CLR;
        result_en      = 1'b0;
        add_en         = 1'b0;
        shamt          = 4'd0;
        if (!reset) begin
            unique case (state)
                STATE_IDLE: begin
                    req_rdy   = 1'b1;
                    result_en = 1'b1;
                end
                STATE_CALC: begin
                    a_mux_sel      = A_MUX_SEL_SHIFT;
                    b_mux_sel      = B_MUX_SEL_SHIFT;
                    result_mux_sel = RESULT_MUX_SEL_ADD;
                    if (!b_zero) begin
                        result_en = 1'b1;
                        add_en    = b_lsbs[0];
                        shamt     = (cz == 4'd0) ? 4'd1 : cz;
                    end
                end
                STATE_DONE: begin
                    // Shift by zero so a/b hold while the response waits.
                    resp_val       = 1'b1;
                    a_mux_sel      = A_MUX_SEL_SHIFT;
                    b_mux_sel      = B_MUX_SEL_SHIFT;
                    result_mux_sel = RESULT_MUX_SEL_ADD;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_plab1_imul_var_lat_ctrl.sv
// Bench for the multiplier control unit with a behavioural shift/add
// datapath and a product scoreboard.
module tb_plab1_imul_var_lat_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_val;
    logic        req_rdy;
    logic        resp_val;
    logic        resp_rdy;
    logic [7:0]  b_lsbs;
    logic        b_zero;
    logic        a_mux_sel;
    logic        b_mux_sel;
    logic        result_mux_sel;
    logic        result_en;
    logic        add_en;
    logic [3:0]  shamt;
    logic [6:0]  calc_count;

    logic [31:0] req_a, req_b;
    logic [31:0] a_reg, b_reg, result_reg;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [31:0] sb_q[$];
    logic [3:0]  sh_trace[$];
    logic        add_trace[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] prod;
        logic [6:0]  cnt;
        int          hold;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    plab1_imul_var_lat_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .req_val        (req_val),
        .req_rdy        (req_rdy),
        .resp_val       (resp_val),
        .resp_rdy       (resp_rdy),
        .b_lsbs         (b_lsbs),
        .b_zero         (b_zero),
        .a_mux_sel      (a_mux_sel),
        .b_mux_sel      (b_mux_sel),
        .result_mux_sel (result_mux_sel),
        .result_en      (result_en),
        .add_en         (add_en),
        .shamt          (shamt),
        .calc_count     (calc_count)
    );

    assign b_lsbs = b_reg[7:0];
    assign b_zero = (b_reg == 32'd0);

    always @(posedge clk) begin
        a_reg <= a_mux_sel ? (a_reg << shamt) : req_a;
        b_reg <= b_mux_sel ? (b_reg >> shamt) : req_b;
        if (result_en)
            result_reg <= result_mux_sel ?
                (add_en ? result_reg + a_reg : result_reg) : 32'd0;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else
            pass_cnt++;
    endtask

    // Independent cycle-count model of the zero-skipping algorithm.
    function automatic logic [6:0] model_cnt(input logic [31:0] b);
        int n = 0;
        while (b != 0) begin
            if (b[7:0] == 8'd0) b = b >> 8;
            else if (b[0]) b = b >> 1;
            else begin
                int z = 0;
                while (!b[z]) z++;
                b = b >> z;
            end
            n++;
        end
        return 7'(n + 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input logic [31:0] a, input logic [31:0] b,
                           input logic [6:0] exp_cnt, input int hold);
        int n;
        logic [6:0] frozen;
        n = 0;
        while (!req_rdy && n < 20) begin tick(); n++; end
        chk("req_rdy_before_accept", {31'd0, req_rdy}, 32'd1);
        req_a   = a;
        req_b   = b;
        req_val = 1'b1;
        sb_q.push_back(a * b);
        tick();
        req_val = 1'b0;
        sh_trace.delete();
        add_trace.delete();
        n = 0;
        while (!resp_val && n < 100) begin
            sh_trace.push_back(shamt);
            add_trace.push_back(add_en);
            tick();
            n++;
        end
        chk("resp_val_timeout", {31'd0, resp_val}, 32'd1);
        chk("calc_count", {25'd0, calc_count}, {25'd0, exp_cnt});
        frozen = calc_count;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_resp_val", {31'd0, resp_val}, 32'd1);
            chk("hold_req_rdy", {31'd0, req_rdy}, 32'd0);
            chk("hold_result_en", {31'd0, result_en}, 32'd0);
            chk("hold_calc_count", {25'd0, calc_count}, {25'd0, frozen});
        end
        if (sb_q.size() != 0)
            chk("product", result_reg, sb_q.pop_front());
        else
            chk("scoreboard_empty", 32'd1, 32'd0);
        resp_rdy = 1'b1;
        tick();
        resp_rdy = 1'b0;
        chk("idle_req_rdy", {31'd0, req_rdy}, 32'd1);
        chk("idle_resp_val", {31'd0, resp_val}, 32'd0);
    endtask

    initial begin
        int adds;
        vecs[0] = '{32'd3, 32'd5, 32'd15, 7'd4, 0};
        vecs[1] = '{32'h1234, 32'd0, 32'd0, 7'd1, 0};
        vecs[2] = '{32'd1, 32'h8000_0000, 32'h8000_0000, 7'd6, 0};
        vecs[3] = '{32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7'd33, 5};
        vecs[4] = '{32'd7, 32'd6, 32'd42, 7'd4, 0};
        vecs[5] = '{32'hABCD, 32'h0001_0100,
                    32'hABCD * 32'h0001_0100,
                    model_cnt(32'h0001_0100), 0};
        vecs[6] = '{32'h1357, 32'h0F0F_0003,
                    32'h1357 * 32'h0F0F_0003,
                    model_cnt(32'h0F0F_0003), 2};

        reset    = 1'b1;
        req_val  = 1'b0;
        resp_rdy = 1'b0;
        req_a    = 32'd0;
        req_b    = 32'd0;
        tick();
        chk("rst_req_rdy", {31'd0, req_rdy}, 32'd0);
        chk("rst_resp_val", {31'd0, resp_val}, 32'd0);
        chk("rst_result_en", {31'd0, result_en}, 32'd0);
        chk("rst_shamt", {28'd0, shamt}, 32'd0);
        chk("rst_calc_count", {25'd0, calc_count}, 32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_req_rdy", {31'd0, req_rdy}, 32'd1);
        chk("idle_result_en", {31'd0, result_en}, 32'd1);
        tick();

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i].a, vecs[i].b, vecs[i].cnt, vecs[i].hold);
            if (i == 2) begin
                chk("trace_len_b80", sh_trace.size(), 32'd6);
                if (sh_trace.size() == 6) begin
                    chk("sh0", {28'd0, sh_trace[0]}, 32'd8);
                    chk("sh1", {28'd0, sh_trace[1]}, 32'd8);
                    chk("sh2", {28'd0, sh_trace[2]}, 32'd8);
                    chk("sh3", {28'd0, sh_trace[3]}, 32'd7);
                    chk("sh4", {28'd0, sh_trace[4]}, 32'd1);
                    chk("sh5_detect", {28'd0, sh_trace[5]}, 32'd0);
                    chk("add3", {31'd0, add_trace[3]}, 32'd0);
                    chk("add4", {31'd0, add_trace[4]}, 32'd1);
                end
            end
            if (i == 3) begin
                adds = 0;
                foreach (add_trace[k]) if (add_trace[k]) adds++;
                chk("ones_add_cycles", adds, 32'd32);
            end
        end

        // Asynchronous reset in the middle of a long CALC.
        req_a   = 32'd9;
        req_b   = 32'hFFFF_FFFF;
        req_val = 1'b1;
        tick();
        req_val = 1'b0;
        tick();
        tick();
        chk("midcalc_count_before", {25'd0, calc_count}, 32'd2);
        #3 reset = 1'b1;
        #1;
        chk("arst_req_rdy", {31'd0, req_rdy}, 32'd0);
        chk("arst_resp_val", {31'd0, resp_val}, 32'd0);
        chk("arst_result_en", {31'd0, result_en}, 32'd0);
        chk("arst_calc_count", {25'd0, calc_count}, 32'd0);
        tick();
        #2 reset = 1'b0;
        #1;
        chk("arst_idle_req_rdy", {31'd0, req_rdy}, 32'd1);
        tick();
        run_txn(32'd7, 32'd6, 7'd4, 0);
        chk("scoreboard_drained", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/plab1_imul_var_lat_ctrl.md
Name: plab1_imul_var_lat_ctrl

Overview:
- Control unit for the variable-latency iterative 32-bit integer multiplier.
- Sequences the shared shift/add datapath: loads operands, adds, and skips runs of zero multiplier bits.
- Computes each cycle's shift amount from the multiplier's low byte via the team's 8-bit trailing-zero counter.
- Sits between the val/rdy request/response ports and the datapath (a_reg shifts left, b_reg shifts right, result_reg accumulates).

Parameters:
- p_nbits, 32, operand width; sizes the calc_count statistic counter to clog2(p_nbits)+2 bits (7 bits at default).

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- req_val  input  1  request valid
- req_rdy  output  1  controller can accept a request
- resp_val  output  1  product valid in result_reg
- resp_rdy  input  1  consumer accepts response
- b_lsbs  input  8  b_reg[7:0] from datapath
- b_zero  input  1  b_reg == 0 from datapath
- a_mux_sel  output  1  0 = load req operand, 1 = shifted a
- b_mux_sel  output  1  0 = load req operand, 1 = shifted b
- result_mux_sel  output  1  0 = clear to 0, 1 = adder output
- result_en  output  1  write enable for result_reg
- add_en  output  1  1 = adder sums result+a, 0 = passes result
- shamt  output  4  shift amount applied to a (left) and b (right), 1..8
- calc_count  output  7  CALC cycles spent by the last completed or in-flight transaction

Behaviour:
- Reset is asynchronous and active-high: state=IDLE, calc_count=0 immediately, independent of clk.
- While reset is asserted, all outputs are 0: req_rdy=0 (gated by !reset), resp_val=0, result_en=0, shamt=0.
- States: IDLE, CALC, DONE (2-bit encoding).
- IDLE:
  - req_rdy=1, a_mux_sel=0, b_mux_sel=0, result_mux_sel=0, result_en=1, add_en=0, shamt=0.
  - req_val=1 -> operands load, result clears; next state CALC; calc_count<=0.
- CALC:
  - req_rdy=0, resp_val=0; a_mux_sel=b_mux_sel=result_mux_sel=1; calc_count increments by 1 each cycle (saturates at all-ones).
  - cz = trailing zeros of b_lsbs (0..8; 8 when b_lsbs==0).
  - If b_zero=1: result_en=0, shamt=0, next state DONE. This detect cycle counts in calc_count.
  - Else add_en=b_lsbs[0]; result_en=1; shamt = 1 when cz==0, else cz; stay in CALC.
  - b_lsbs==0 with b_zero=0 -> shamt=8, add_en=0 (skip a whole byte).
- DONE:
  - resp_val=1, result_en=0, req_rdy=0.
  - resp_rdy=1 -> IDLE. No new request is accepted in the same cycle; request acceptance is IDLE-only.
- Latency: 1 accept cycle + (#update cycles + 1) CALC cycles + at least 1 DONE cycle. Worst case for 32-bit b=0xFFFFFFFF: calc_count=33.
- Each CALC update shifts b by at least 1, so termination is guaranteed within p_nbits+1 CALC cycles.
- Control outputs are combinational from state, b_lsbs and b_zero. No registered outputs except calc_count.
- Reset mid-operation in CALC or DONE: transaction is abandoned and no response is produced. The datapath register contents do not matter; the next IDLE load clears them.
- resp_val held with resp_rdy=0: state stays DONE indefinitely, and calc_count and all datapath enables stay frozen.

Decomposition:
- Shared package/header holds:
  - state encodings STATE_IDLE=0, STATE_CALC=1, STATE_DONE=2
  - mux select constants: a/b LD=0, SHIFT=1; result CLR=0, ADD=1
- One sub-module instance: plab1_imul_CountZeros (8-bit trailing-zero counter) on b_lsbs, producing cz.
- The FSM, output decode and calc_count counter stay in this module.

Test Plan:
- a=3, b=5: IDLE accept, then CALC shamt sequence 1 (add), 1 (no add), 1 (add), detect -> resp product 15, calc_count=4.
- b=0: accept, first CALC cycle sees b_zero -> DONE next cycle, product 0, calc_count=1.
- a=1, b=0x80000000: shamt sequence 8, 8, 8, 7, 1 (add only on the last), then detect -> product 0x80000000, calc_count=6.
- b=0xFFFFFFFF: 32 consecutive add cycles with shamt=1 -> calc_count=33; with a=1, product 0xFFFFFFFF.
- Hold resp_rdy=0 for 5 cycles in DONE: resp_val stays 1, req_rdy stays 0, result_en=0, calc_count unchanged; then resp_rdy=1 -> IDLE, req_rdy=1 next cycle.
- Assert reset asynchronously mid-CALC (between edges): req_rdy/resp_val/result_en drop to 0 immediately and calc_count=0; after release the FSM is in IDLE and accepts a new request a=7, b=6 -> product 42.
